// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a valid/ready handshake and a 2-entry skid buffer.
// Decodes I/S/B/U/J/CSR-zimm immediates and counts delivered illegal opcodes.
module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 32,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_imm,
  output logic [2:0]         out_type,
  output logic               out_illegal,
  output logic [TAG_W-1:0]   out_tag,
  output logic [COUNT_W-1:0] illegal_count
);

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
  localparam logic [2:0] T_Z    = 3'd6;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       kind;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t             state_q, state_d;
  entry_t             main_q, main_d;
  entry_t             skid_q, skid_d;
  entry_t             dec;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic signed [31:0] s32;
  logic               accept;
  logic               deliver;

  // Immediates are placed at the top of a 32-bit word and arithmetic-shifted down
  // so the sign of bit 31 propagates without explicit replication.
  always_comb begin
    s32      = '0;
    dec.kind = T_NONE;
    dec.ill  = 1'b0;
    dec.tag  = in_tag;
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec.kind = T_I;
        s32      = $signed(in_instr) >>> 20;
      end
      7'b0100011: begin
        dec.kind = T_S;
        s32      = $signed({in_instr[31:25], in_instr[11:7], 20'b0}) >>> 20;
      end
      7'b1100011: begin
        dec.kind = T_B;
        s32      = $signed({in_instr[31], in_instr[7], in_instr[30:25],
                            in_instr[11:8], 20'b0}) >>> 19;
      end
      7'b0110111, 7'b0010111: begin
        dec.kind = T_U;
        s32      = $signed({in_instr[31:12], 12'b0});
      end
      7'b1101111: begin
        dec.kind = T_J;
        s32      = $signed({in_instr[31], in_instr[19:12], in_instr[20],
                            in_instr[30:21], 12'b0}) >>> 11;
      end
      7'b1110011: begin
        if (in_instr[14]) begin
          dec.kind = T_Z;
          s32      = {27'b0, in_instr[19:15]};
        end
      end
      7'b0110011, 7'b0001111: dec.kind = T_NONE;
      default: dec.ill = 1'b1;
    endcase
    dec.imm = XLEN'(s32);
  end

  assign out_valid     = (state_q != EMPTY);
  assign in_ready      = (state_q != FULL);
  assign out_imm       = main_q.imm;
  assign out_type      = main_q.kind;
  assign out_illegal   = main_q.ill;
  assign out_tag       = main_q.tag;
  assign illegal_count = cnt_q;

  assign accept  = in_valid & in_ready & ~flush;
  assign deliver = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    if (deliver && main_q.ill) cnt_d = sat_inc(cnt_q);
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = dec;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          main_d = dec;
        end else if (accept) begin
          skid_d  = dec;
          state_d = FULL;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // A flush empties both slots; a deliver in the same cycle has already completed.
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
